// File: rtl/ctrl_sequencer_if.sv
// Datapath control strobes driven by the sequencer.
// master = sequencer, slave = datapath control pins.
interface ctrl_sequencer_if #(
  parameter int NREGS = 16,
  parameter int ALU_W = 12
);
  logic [NREGS-1:0] reg_out;
  logic [NREGS-1:0] reg_in;
  logic             pc_out;
  logic             mar_in;
  logic             inc_pc;
  logic             pc_in;
  logic             mdr_read;
  logic             mdr_in;
  logic             mdr_out;
  logic             ir_in_en;
  logic             y_in;
  logic             z_in;
  logic             zlow_out;
  logic [ALU_W-1:0] alu_ctrl;

  modport master (
    output reg_out, reg_in,
    output pc_out, mar_in, inc_pc, pc_in,
    output mdr_read, mdr_in, mdr_out, ir_in_en,
    output y_in, z_in, zlow_out,
    output alu_ctrl
  );

  modport slave (
    input reg_out, reg_in,
    input pc_out, mar_in, inc_pc, pc_in,
    input mdr_read, mdr_in, mdr_out, ir_in_en,
    input y_in, z_in, zlow_out,
    input alu_ctrl
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/execute control unit for the shared-bus datapath.
// Moore strobes decoded from the state register plus the IR fields.
module ctrl_sequencer #(
  parameter int NREGS    = 16,
  parameter int ALU_W    = 12,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_run,
  input  logic             i_mem_ready,
  input  logic [31:0]      i_ir_in,
  ctrl_sequencer_if.master dp,
  output logic [2:0]       o_step,
  output logic             o_done,
  output logic             o_illegal,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_icount
);

  localparam int WW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WW-1:0]    r_wait;
  logic             r_run_q;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_icount;

  logic [4:0]       w_op;
  logic [3:0]       w_ra;
  logic [3:0]       w_rb;
  logic [3:0]       w_rc;
  logic             w_legal;
  logic             w_timeout;
  logic             w_unused;

  assign w_op     = i_ir_in[31:27];
  assign w_ra     = i_ir_in[26:23];
  assign w_rb     = i_ir_in[22:19];
  assign w_rc     = i_ir_in[18:15];
  assign w_unused = ^i_ir_in[14:0];
  assign w_legal  = (w_op >= 5'd2) && (w_op <= 5'd13);

  // last permitted T1 wait cycle with memory still not ready
  assign w_timeout = (r_state == S_T1) && !i_mem_ready
                   && (r_wait == WW'(WAIT_MAX - 1));

  always_comb begin
    w_next      = r_state;
    dp.reg_out  = '0;
    dp.reg_in   = '0;
    dp.pc_out   = 1'b0;
    dp.mar_in   = 1'b0;
    dp.inc_pc   = 1'b0;
    dp.pc_in    = 1'b0;
    dp.mdr_read = 1'b0;
    dp.mdr_in   = 1'b0;
    dp.mdr_out  = 1'b0;
    dp.ir_in_en = 1'b0;
    dp.y_in     = 1'b0;
    dp.z_in     = 1'b0;
    dp.zlow_out = 1'b0;
    dp.alu_ctrl = '0;
    o_done      = 1'b0;
    o_illegal   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_run) w_next = S_T0;
      end
      S_T0: begin
        dp.pc_out = 1'b1;
        dp.mar_in = 1'b1;
        dp.inc_pc = 1'b1;
        dp.z_in   = 1'b1;
        w_next    = S_T1;
      end
      S_T1: begin
        dp.zlow_out = 1'b1;
        dp.pc_in    = 1'b1;
        dp.mdr_read = 1'b1;
        dp.mdr_in   = 1'b1;
        if (i_mem_ready) w_next = S_T2;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_T2: begin
        dp.mdr_out  = 1'b1;
        dp.ir_in_en = 1'b1;
        w_next      = S_T3;
      end
      S_T3: begin
        if (w_legal) begin
          dp.reg_out = NREGS'(1) << w_rb;
          dp.y_in    = 1'b1;
          w_next     = S_T4;
        end else begin
          o_illegal = 1'b1;
          w_next    = i_run ? S_T0 : S_IDLE;
        end
      end
      S_T4: begin
        dp.reg_out = NREGS'(1) << w_rc;
        dp.z_in    = 1'b1;
        if (w_legal) dp.alu_ctrl = ALU_W'(1) << (w_op - 5'd2);
        w_next = S_T5;
      end
      S_T5: begin
        dp.zlow_out = 1'b1;
        dp.reg_in   = NREGS'(1) << w_ra;
        o_done      = 1'b1;
        w_next      = i_run ? S_T0 : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_run_q   <= 1'b0;
      r_mem_err <= 1'b0;
      r_icount  <= '0;
    end else begin
      r_state <= w_next;
      r_run_q <= i_run;
      if (r_state == S_T1 && !i_mem_ready && !w_timeout)
        r_wait <= r_wait + WW'(1);
      else
        r_wait <= '0;
      if (w_timeout)
        r_mem_err <= 1'b1;
      else if (i_run && !r_run_q)
        r_mem_err <= 1'b0;
      if (r_state == S_T5)
        r_icount <= r_icount + CNT_W'(1);
    end
  end

  assign o_step    = r_state;
  assign o_mem_err = r_mem_err;
  assign o_icount  = r_icount;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer with a retirement scoreboard.
// A second instance with a 2-bit counter exercises icount wrap.
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        run;
  logic        ready;
  logic [31:0] ir;

  logic [2:0]  step, step2;
  logic        done, done2, ill, ill2, merr, merr2;
  logic [15:0] icnt;
  logic [1:0]  icnt2;

  ctrl_sequencer_if #(.NREGS(16), .ALU_W(12)) dpi ();
  ctrl_sequencer_if #(.NREGS(16), .ALU_W(12)) dpi2 ();

  ctrl_sequencer dut (
    .clk(clk), .clr(clr), .i_run(run), .i_mem_ready(ready),
    .i_ir_in(ir), .dp(dpi), .o_step(step), .o_done(done),
    .o_illegal(ill), .o_mem_err(merr), .o_icount(icnt)
  );

  ctrl_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .i_run(run), .i_mem_ready(ready),
    .i_ir_in(ir), .dp(dpi2), .o_step(step2), .o_done(done2),
    .o_illegal(ill2), .o_mem_err(merr2), .o_icount(icnt2)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] IR_ROL = 32'h4A92_0000;
  localparam logic [31:0] IR_ADD = 32'h1089_8000;
  localparam logic [31:0] IR_BAD = 32'hF800_0000;

  logic [10:0] sc;
  assign sc = {dpi.pc_out, dpi.mar_in, dpi.inc_pc, dpi.pc_in,
               dpi.mdr_read, dpi.mdr_in, dpi.mdr_out, dpi.ir_in_en,
               dpi.y_in, dpi.z_in, dpi.zlow_out};

  typedef struct {
    logic        is_ill;
    logic [15:0] regin;
    logic [15:0] icnt;
  } sb_t;

  sb_t sbq[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] exp_sc(input int j);
    case (j)
      1: return 11'h702;
      2: return 11'h0E1;
      3: return 11'h018;
      4: return 11'h004;
      5: return 11'h002;
      6: return 11'h001;
      default: return 11'h000;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_step(input logic [2:0] s, input int maxc);
    int n = 0;
    while (step !== s && n < maxc) begin
      tick();
      n++;
    end
    chk("wait_step", 64'(step), 64'(s));
  endtask

  task automatic push(input logic i, input logic [15:0] r,
                      input logic [15:0] c);
    sb_t e;
    e.is_ill = i;
    e.regin  = r;
    e.icnt   = c;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      chk("onehot_reg_out", 64'($onehot0(dpi.reg_out)), 64'd1);
      chk("onehot_reg_in", 64'($onehot0(dpi.reg_in)), 64'd1);
      chk("onehot_alu", 64'($onehot0(dpi.alu_ctrl)), 64'd1);
      chk("bus_driver", 64'($onehot0({|dpi.reg_out, dpi.pc_out,
          dpi.mdr_out, dpi.zlow_out})), 64'd1);
      if (done || ill) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected", 64'(done), 64'(ill));
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("sb_done", 64'(done), 64'(!e.is_ill));
          chk("sb_illegal", 64'(ill), 64'(e.is_ill));
          chk("sb_reg_in", 64'(dpi.reg_in), 64'(e.regin));
          chk("sb_icount", 64'(icnt), 64'(e.icnt));
        end
      end
    end
  end

  initial begin
    clr   = 1'b1;
    run   = 1'b0;
    ready = 1'b0;
    ir    = '0;
    tick();
    tick();
    clr = 1'b0;
    tick();
    chk("rst_step", 64'(step), 64'd0);
    chk("rst_strobes", {dpi.reg_out, dpi.reg_in, dpi.alu_ctrl, sc,
        done, ill, merr}, 64'd0);
    chk("rst_icount", 64'(icnt), 64'd0);

    // single ROL R5 <- R2, R4
    ir    = IR_ROL;
    ready = 1'b1;
    run   = 1'b1;
    push(1'b0, 16'h0020, 16'd0);
    tick();
    chk("rol_t0_step", 64'(step), 64'd1);
    chk("rol_t0_sc", 64'(sc), 64'(exp_sc(1)));
    run = 1'b0;
    tick();
    chk("rol_t1_sc", 64'(sc), 64'(exp_sc(2)));
    tick();
    chk("rol_t2_sc", 64'(sc), 64'(exp_sc(3)));
    tick();
    chk("rol_t3_step", 64'(step), 64'd4);
    chk("rol_t3_reg_out", 64'(dpi.reg_out), 64'h0004);
    chk("rol_t3_sc", 64'(sc), 64'(exp_sc(4)));
    tick();
    chk("rol_t4_reg_out", 64'(dpi.reg_out), 64'h0010);
    chk("rol_t4_alu", 64'(dpi.alu_ctrl), 64'h080);
    chk("rol_t4_sc", 64'(sc), 64'(exp_sc(5)));
    tick();
    chk("rol_t5_reg_in", 64'(dpi.reg_in), 64'h0020);
    chk("rol_t5_done", 64'(done), 64'd1);
    chk("rol_t5_sc", 64'(sc), 64'(exp_sc(6)));
    tick();
    chk("rol_idle", 64'(step), 64'd0);
    chk("rol_icount", 64'(icnt), 64'd1);
    chk("rol_icount2", 64'(icnt2), 64'd1);

    // clr held two cycles in the middle of T4
    run = 1'b1;
    tick();
    run = 1'b0;
    wait_step(3'd5, 10);
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    chk("clr_step", 64'(step), 64'd0);
    chk("clr_strobes", {dpi.reg_out, dpi.reg_in, dpi.alu_ctrl, sc,
        done, ill, merr}, 64'd0);
    chk("clr_icount", 64'(icnt), 64'd0);
    chk("clr_icount2", 64'(icnt2), 64'd0);

    // T1 wait: memory not ready on three sampling edges
    ready = 1'b0;
    run   = 1'b1;
    push(1'b0, 16'h0020, 16'd0);
    tick();
    chk("wait_t0", 64'(step), 64'd1);
    run = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wait_in_t1", 64'(step), 64'd2);
      if (i == 3) ready = 1'b1;
      tick();
    end
    chk("wait_to_t2", 64'(step), 64'd3);
    wait_step(3'd0, 10);
    chk("wait_icount", 64'(icnt), 64'd1);

    // fetch timeout
    ready = 1'b0;
    run   = 1'b1;
    tick();
    run = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("tmo_in_t1", 64'(step), 64'd2);
      tick();
    end
    chk("tmo_step", 64'(step), 64'd0);
    chk("tmo_mem_err", 64'(merr), 64'd1);
    chk("tmo_icount", 64'(icnt), 64'd1);
    tick();
    chk("tmo_sticky", 64'(merr), 64'd1);

    // illegal opcode; run rising edge clears mem_err
    ir    = IR_BAD;
    ready = 1'b1;
    run   = 1'b1;
    push(1'b1, 16'h0000, 16'd1);
    tick();
    chk("ill_merr_clr", 64'(merr), 64'd0);
    chk("ill_t0", 64'(step), 64'd1);
    run = 1'b0;
    wait_step(3'd4, 5);
    chk("ill_pulse", 64'(ill), 64'd1);
    chk("ill_no_strobe", {dpi.reg_out, dpi.reg_in, sc}, 64'd0);
    tick();
    chk("ill_idle", 64'(step), 64'd0);
    chk("ill_icount", 64'(icnt), 64'd1);

    // three back-to-back ADDs, run dropped in the third T1
    ir    = IR_ADD;
    ready = 1'b1;
    run   = 1'b1;
    push(1'b0, 16'h0002, 16'd1);
    push(1'b0, 16'h0002, 16'd2);
    push(1'b0, 16'h0002, 16'd3);
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int j = 1; j <= 6; j++) begin
        chk("b2b_step", 64'(step), 64'(j));
        chk("b2b_sc", 64'(sc), 64'(exp_sc(j)));
        if (j == 4) chk("b2b_rb", 64'(dpi.reg_out), 64'h0002);
        if (j == 5) chk("b2b_rc", 64'(dpi.reg_out), 64'h0008);
        if (j == 5) chk("b2b_alu", 64'(dpi.alu_ctrl), 64'h001);
        if (k == 2 && j == 2) run = 1'b0;
        tick();
      end
    end
    chk("b2b_idle", 64'(step), 64'd0);
    chk("b2b_icount", 64'(icnt), 64'd4);
    chk("wrap_icount2", 64'(icnt2), 64'd0);
    tick();
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
